// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; the result is registered and held until the owner accepts it.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_data1,
  input  logic [WIDTH-1:0]  req0_data2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_data1,
  input  logic [WIDTH-1:0]  req1_data2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic [WIDTH-1:0]  alu_data1,
  output logic [WIDTH-1:0]  alu_data2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic               last_grant;
  logic               grant_id;
  logic               grant;
  logic               accept;
  logic               owner_ready;
  logic [WIDTH-1:0]   op1_q;
  logic [WIDTH-1:0]   op2_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [WIDTH-1:0]   res_q;
  logic               zero_q;
  logic               rsp0_valid_q;
  logic               rsp1_valid_q;

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = ~last_grant;
    else if (req1_valid)
      grant = 1'b1;
  end

  assign req0_ready  = (state == IDLE) && req0_valid && !grant;
  assign req1_ready  = (state == IDLE) && req1_valid && grant;
  assign accept      = req0_ready || req1_ready;
  assign owner_ready = grant_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op1_q      <= grant ? req1_data1 : req0_data1;
            op2_q      <= grant ? req1_data2 : req0_data2;
            ctrl_q     <= grant ? req1_ctrl  : req0_ctrl;
            grant_id   <= grant;
            last_grant <= grant;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          if (grant_id)
            rsp1_valid_q <= 1'b1;
          else
            rsp0_valid_q <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outside EXEC the ALU sees zero operands and the unused all-ones code.
  assign alu_data1 = (state == EXEC) ? op1_q  : '0;
  assign alu_data2 = (state == EXEC) ? op2_q  : '0;
  assign alu_ctrl  = (state == EXEC) ? ctrl_q : {CTRL_W{1'b1}};

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, expected-response scoreboard,
// and a negedge monitor checking grant order, latency, and idle ALU inputs.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_data1 = '0, req0_data2 = '0, req1_data1 = '0, req1_data2 = '0;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0]  rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero;
  logic [W-1:0]  alu_data1, alu_data2, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_zero;
  logic          busy;

  typedef struct {
    logic         id;
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t          sb[$];
  int            acc_q[$];
  int            passed = 0;
  int            fails = 0;
  int            total = 0;
  int            cyc = 0;
  int            exec_cyc = -10;
  bit            mon_en = 1'b0;
  bit            exp_busy = 1'b0;
  bit            prev_rsp = 1'b0;
  logic [W-1:0]  exp_d1 = '0, exp_d2 = '0;
  logic [CW-1:0] exp_ctrl = '0;

  alu_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_ctrl(req0_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_ctrl(req1_ctrl),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: RISC-V style control codes, 1111 and other unused codes give 0.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_data1 + alu_data2;
      4'b0001: alu_result = alu_data1 - alu_data2;
      4'b0010: alu_result = alu_data1 & alu_data2;
      4'b0011: alu_result = alu_data1 | alu_data2;
      4'b0100: alu_result = alu_data1 ^ alu_data2;
      4'b0111: alu_result = $unsigned($signed(alu_data1) >>> alu_data2[4:0]);
      4'b1000: alu_result = {31'd0, $signed(alu_data1) < $signed(alu_data2)};
      4'b1010: alu_result = alu_data2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResponse(input logic id, input logic [W-1:0] res, input logic zero);
    exp_t e;
    checkOutput("rsp_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("rsp_id", 32'(id), 32'(e.id));
      checkOutput("rsp_result", res, e.res);
      checkOutput("rsp_zero", 32'(zero), 32'(e.zero));
    end
  endtask

  // Monitor sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
      if (exp_busy) checkOutput("ready_when_busy", 32'(req0_ready | req1_ready), 32'd0);
      checkOutput("rsp_excl", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (cyc == exec_cyc) begin
        checkOutput("alu_ctrl_exec", 32'(alu_ctrl), 32'(exp_ctrl));
        checkOutput("alu_d1_exec", alu_data1, exp_d1);
        checkOutput("alu_d2_exec", alu_data2, exp_d2);
      end else begin
        checkOutput("alu_ctrl_idle", 32'(alu_ctrl), 32'hF);
        checkOutput("alu_data_idle", alu_data1 | alu_data2, 32'd0);
      end
      if (reset) begin
        sb.delete();
        exp_busy = 1'b0;
        prev_rsp = 1'b0;
      end else begin
        if ((rsp0_valid || rsp1_valid) && !prev_rsp && acc_q.size() != 0)
          checkOutput("latency", 32'(cyc - acc_q[$]), 32'd2);
        prev_rsp = rsp0_valid || rsp1_valid;
        if (rsp0_valid && rsp0_ready) begin
          checkResponse(1'b0, rsp0_result, rsp0_zero);
          exp_busy = 1'b0;
        end
        if (rsp1_valid && rsp1_ready) begin
          checkResponse(1'b1, rsp1_result, rsp1_zero);
          exp_busy = 1'b0;
        end
        if (req0_valid && req0_ready) begin
          acc_q.push_back(cyc);
          exec_cyc = cyc + 1;
          exp_d1 = req0_data1; exp_d2 = req0_data2; exp_ctrl = req0_ctrl;
          exp_busy = 1'b1;
        end
        if (req1_valid && req1_ready) begin
          acc_q.push_back(cyc);
          exec_cyc = cyc + 1;
          exp_d1 = req1_data1; exp_d2 = req1_data2; exp_ctrl = req1_ctrl;
          exp_busy = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic id, input logic [W-1:0] d1, input logic [W-1:0] d2,
                               input logic [CW-1:0] c);
    if (id) begin
      req1_data1 = d1; req1_data2 = d2; req1_ctrl = c; req1_valid = 1'b1;
    end else begin
      req0_data1 = d1; req0_data2 = d2; req0_ctrl = c; req0_valid = 1'b1;
    end
  endtask

  task automatic pushExpect(input logic id, input logic [W-1:0] res, input logic zero);
    exp_t e;
    e.id = id; e.res = res; e.zero = zero;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the requester's ready, clocks the handshake, then drops valid.
  task automatic waitAccept(input logic id);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(id ? "accept1" : "accept0", 32'(got), 32'd1);
    tick();
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic waitDone();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    checkOutput("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;

    doReset();
    checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_result", rsp0_result, 32'd0);
    checkOutput("reset_zero", 32'(rsp0_zero), 32'd0);
    checkOutput("reset_alu_ctrl", 32'(alu_ctrl), 32'hF);

    // Single add: 5 + 7, response one EXEC cycle after the handshake.
    pushExpect(1'b0, 32'd12, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd7, 4'b0000);
    waitAccept(1'b0);
    checkOutput("add_busy", 32'(busy), 32'd1);
    checkOutput("add_not_yet", 32'(rsp0_valid), 32'd0);
    tick();
    checkOutput("add_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("add_result", rsp0_result, 32'd12);
    checkOutput("add_zero", 32'(rsp0_zero), 32'd0);
    checkOutput("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
    waitDone();

    // Simultaneous requests after reset: requester 0 goes first.
    doReset();
    pushExpect(1'b0, 32'd0, 1'b1);
    pushExpect(1'b1, 32'h0000_00FF, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd9, 4'b0001);
    applyStimulus(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0011);
    #1;
    checkOutput("both_ready0", 32'(req0_ready), 32'd1);
    checkOutput("both_ready1", 32'(req1_ready), 32'd0);
    waitAccept(1'b0);
    waitAccept(1'b1);
    waitDone();

    // Both held valid: alternating grants, one accept every 3 cycles.
    base = acc_q.size();
    pushExpect(1'b0, 32'd101, 1'b0);
    pushExpect(1'b1, 32'd202, 1'b0);
    pushExpect(1'b0, 32'd101, 1'b0);
    pushExpect(1'b1, 32'd202, 1'b0);
    applyStimulus(1'b0, 32'd100, 32'd1, 4'b0000);
    applyStimulus(1'b1, 32'd200, 32'd2, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_q.size() - base >= 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rr_accepts", 32'(acc_q.size() - base), 32'd4);
    if (acc_q.size() - base >= 4)
      for (int i = 0; i < 3; i++)
        checkOutput("rr_spacing", 32'(acc_q[base + i + 1] - acc_q[base + i]), 32'd3);
    waitDone();

    // Stalled response: result held, requester 0 locked out until transfer.
    pushExpect(1'b1, 32'hF800_0000, 1'b0);
    pushExpect(1'b0, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd4, 4'b0111);
    waitAccept(1'b1);
    rsp1_ready = 1'b0;
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1000);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 32'(rsp1_valid), 32'd1);
      checkOutput("stall_result", rsp1_result, 32'hF800_0000);
      checkOutput("stall_no_ready", 32'(req0_ready | req1_ready), 32'd0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    checkOutput("stall_released", 32'(rsp1_valid), 32'd0);
    waitAccept(1'b0);
    waitDone();

    // Pass-through of operand 2.
    pushExpect(1'b1, 32'h1234_5000, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1234_5000, 4'b1010);
    waitAccept(1'b1);
    waitDone();

    // Reset during EXEC drops the operation and restores requester 0 priority.
    applyStimulus(1'b0, 32'd3, 32'd4, 4'b0000);
    waitAccept(1'b0);
    checkOutput("mid_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_rsp0", 32'(rsp0_valid), 32'd0);
    checkOutput("mid_reset_rsp1", 32'(rsp1_valid), 32'd0);
    repeat (4) tick();
    checkOutput("dropped_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    pushExpect(1'b0, 32'd2, 1'b0);
    pushExpect(1'b1, 32'd6, 1'b0);
    applyStimulus(1'b0, 32'd1, 32'd1, 4'b0000);
    applyStimulus(1'b1, 32'd3, 32'd3, 4'b0000);
    #1;
    checkOutput("post_reset_grant0", 32'(req0_ready), 32'd1);
    checkOutput("post_reset_grant1", 32'(req1_ready), 32'd0);
    waitAccept(1'b0);
    waitAccept(1'b1);
    waitDone();

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
